// File: rtl/seq_mult.sv
// seq_mult: sequential shift-add multiplier with valid/ready handshakes.
// It multiplies an INPUT1_WIDTH multiplicand by an INPUT2_WIDTH multiplier,
// one multiplier bit per clock, in signed (two's complement) or unsigned mode.
// The full-width product is held in z until the sink accepts it.
// Signed products are formed from operand magnitudes and negated at the end,
// so the unsigned datapath handles both modes.

module seq_mult #(
  parameter int INPUT1_WIDTH = 4,
  parameter int INPUT2_WIDTH = 5,
  parameter bit SIGNED_EN    = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 signed_mode,
  input  logic [INPUT1_WIDTH-1:0]              x,
  input  logic [INPUT2_WIDTH-1:0]              y,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] z,
  output logic                                 z_signed,
  output logic                                 busy
);

  localparam int W  = INPUT1_WIDTH + INPUT2_WIDTH;
  localparam int CW = $clog2(INPUT2_WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(INPUT2_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [W-1:0]            mcand;
  logic [INPUT2_WIDTH:0]   mplier;
  logic [W-1:0]            acc;
  logic [CW-1:0]           count;
  logic                    neg;
  logic                    sgn;

  logic                    eff_signed;
  logic [INPUT1_WIDTH:0]   x_mag;
  logic [INPUT2_WIDTH:0]   y_mag;
  logic [W-1:0]            partial;
  logic [W-1:0]            acc_next;

  // Handshake flags come straight from the state register, never from inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);

  // Operand magnitudes (one extra bit so the most negative value is exact)
  // and the next accumulator value for the current multiplier bit.
  always_comb begin
    eff_signed = SIGNED_EN && signed_mode;
    x_mag      = {1'b0, x};
    y_mag      = {1'b0, y};
    if (eff_signed && x[INPUT1_WIDTH-1]) begin
      x_mag = (~{1'b1, x}) + {{INPUT1_WIDTH{1'b0}}, 1'b1};
    end
    if (eff_signed && y[INPUT2_WIDTH-1]) begin
      y_mag = (~{1'b1, y}) + {{INPUT2_WIDTH{1'b0}}, 1'b1};
    end
    partial  = mplier[0] ? (mcand << count) : '0;
    acc_next = acc + partial;
  end

  // Control FSM and datapath: capture in IDLE, one shift-add per BUSY cycle,
  // hold the product in DONE until the sink takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      neg      <= 1'b0;
      sgn      <= 1'b0;
      z        <= '0;
      z_signed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= W'(x_mag);
            mplier <= y_mag;
            acc    <= '0;
            count  <= '0;
            neg    <= eff_signed && (x[INPUT1_WIDTH-1] ^ y[INPUT2_WIDTH-1]);
            sgn    <= eff_signed;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == LAST_COUNT) begin
            z        <= neg ? -acc_next : acc_next;
            z_signed <= sgn;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed and randomised checks of seq_mult at default widths
// (4x5, signed mode enabled). Expected products are hand-computed in the
// vector table or derived from the bench's own integer multiply.

module tb_seq_mult;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       signed_mode;
  logic [3:0] x;
  logic [4:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] z;
  logic       z_signed;
  logic       busy;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] x;
    logic [4:0] y;
    logic       sm;
    logic [8:0] z_exp;
    logic       zs_exp;
  } vec_t;

  vec_t vecs[8];

  seq_mult #(
    .INPUT1_WIDTH(4),
    .INPUT2_WIDTH(5),
    .SIGNED_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .signed_mode(signed_mode),
    .x(x),
    .y(y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z(z),
    .z_signed(z_signed),
    .busy(busy)
  );

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer operands for one edge, then count cycles until out_valid rises
  task automatic applyStimulus(input logic [3:0] xi, input logic [4:0] yi, input logic sm,
                               output int lat);
    @(negedge clk);
    x = xi;
    y = yi;
    signed_mode = sm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Accept the held product and confirm the return to IDLE
  task automatic acceptResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("idle_after_accept.in_ready", in_ready, 1);
    checkOutput("idle_after_accept.out_valid", out_valid, 0);
  endtask

  initial begin
    int         lat;
    int         p;
    int         first_acc;
    int         second_acc;
    logic [3:0] rx;
    logic [4:0] ry;
    logic       rsm;
    logic [8:0] zexp;
    logic [8:0] zhold;

    checks = 0;
    failures = 0;

    vecs[0] = '{x: 4'd15,    y: 5'd31,     sm: 1'b0, z_exp: 9'h1D1, zs_exp: 1'b0};
    vecs[1] = '{x: 4'b1000,  y: 5'b10000,  sm: 1'b1, z_exp: 9'h080, zs_exp: 1'b1};
    vecs[2] = '{x: 4'b1111,  y: 5'b01111,  sm: 1'b1, z_exp: 9'h1F1, zs_exp: 1'b1};
    vecs[3] = '{x: 4'b1111,  y: 5'b01111,  sm: 1'b0, z_exp: 9'h0E1, zs_exp: 1'b0};
    vecs[4] = '{x: 4'd0,     y: 5'b10000,  sm: 1'b1, z_exp: 9'h000, zs_exp: 1'b1};
    vecs[5] = '{x: 4'b1000,  y: 5'b01111,  sm: 1'b1, z_exp: 9'h188, zs_exp: 1'b1};
    vecs[6] = '{x: 4'd1,     y: 5'b10000,  sm: 1'b1, z_exp: 9'h1F0, zs_exp: 1'b1};
    vecs[7] = '{x: 4'd7,     y: 5'b01111,  sm: 1'b1, z_exp: 9'h069, zs_exp: 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    signed_mode = 1'b0;
    x = '0;
    y = '0;
    #1;
    checkOutput("reset.in_ready", in_ready, 1);
    checkOutput("reset.out_valid", out_valid, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.z", z, 0);
    checkOutput("reset.z_signed", z_signed, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven products
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].sm, lat);
      checkOutput($sformatf("vec%0d.latency", i), lat, 5);
      checkOutput($sformatf("vec%0d.z", i), z, vecs[i].z_exp);
      checkOutput($sformatf("vec%0d.z_signed", i), z_signed, vecs[i].zs_exp);
      acceptResult();
    end

    // Backpressure with operand inputs toggling while DONE is held
    applyStimulus(4'd5, 5'd9, 1'b0, lat);
    checkOutput("bp.latency", lat, 5);
    checkOutput("bp.z", z, 9'd45);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      x = 4'($urandom);
      y = 5'($urandom);
      signed_mode = ~signed_mode;
      @(posedge clk);
      #1;
      checkOutput("bp.hold_z", z, 9'd45);
      checkOutput("bp.hold_in_ready", in_ready, 0);
      checkOutput("bp.hold_out_valid", out_valid, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    acceptResult();

    // Reset dropped during the third BUSY cycle
    @(negedge clk);
    x = 4'd9;
    y = 5'd13;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("midreset.busy_first", busy, 1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset.busy", busy, 0);
    checkOutput("midreset.in_ready", in_ready, 1);
    checkOutput("midreset.out_valid", out_valid, 0);
    checkOutput("midreset.z", z, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midreset.no_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'd3, 5'd0, 1'b0, lat);
    checkOutput("postreset.latency", lat, 5);
    checkOutput("postreset.z", z, 0);
    acceptResult();

    // Throughput with in_valid and out_ready both held high
    first_acc = -1;
    second_acc = -1;
    @(negedge clk);
    x = 4'd2;
    y = 5'd3;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (in_ready) begin
        if (first_acc < 0) first_acc = c;
        else if (second_acc < 0) second_acc = c;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("throughput.spacing", second_acc - first_acc, 7);
    repeat (10) @(posedge clk);
    #1;
    if (out_valid) acceptResult();

    // Random operands with random backpressure against integer multiply
    for (int t = 0; t < 40; t++) begin
      rx = 4'($urandom);
      ry = 5'($urandom);
      rsm = 1'($urandom);
      if (rsm) p = int'($signed(rx)) * int'($signed(ry));
      else     p = int'(rx) * int'(ry);
      zexp = p[8:0];
      applyStimulus(rx, ry, rsm, lat);
      checkOutput($sformatf("rand%0d.latency", t), lat, 5);
      checkOutput($sformatf("rand%0d.z", t), z, zexp);
      checkOutput($sformatf("rand%0d.z_signed", t), z_signed, rsm);
      zhold = z;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        checkOutput($sformatf("rand%0d.stall_z", t), z, zhold);
      end
      acceptResult();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
